// File: rtl/display_share_arbiter.sv
// Round-robin sharer of one 8-digit seven-segment driver with a minimum dwell per grant.
// Optional blink of the granted client's digits when DISPLAY_SHARE_BLINK_EN is defined.
module display_share_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned DWELL_CYC  = 50_000_000,
  parameter logic [4:0]  BLANK_CODE = 5'h1F,
  parameter int unsigned BLINK_CYC  = 25_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*40-1:0] req_num,
`ifdef DISPLAY_SHARE_BLINK_EN
  input  logic [NREQ-1:0]   blink,
`endif
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic [39:0]       num
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYC - 1);
  localparam logic [39:0] BLANK = {8{BLANK_CODE}};
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("NREQ must be in 2..8");
  end
  if (DWELL_CYC == 0 || BLINK_CYC == 0) begin : g_bad_cyc
    $error("DWELL_CYC and BLINK_CYC must be nonzero");
  end

  logic [NREQ-1:0] grant_q, grant_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [39:0]     num_q, num_d;
  logic            busy_q;
  logic [0:0]      state;

  logic [NREQ-1:0] pick_oh;
  logic [PW-1:0]   pick_idx;
  logic            pick_found;
  logic            others;
  logic [39:0]     slice;
  logic            blank_now;

  assign state  = (|grant_q) ? ST_SHOW : ST_IDLE;
  assign others = |(req & ~grant_q);

  // First requester at or above ptr; while showing, ptr is always g+1 so g is searched last.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick_oh    = '0;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_found && req[idx]) begin
        pick_found   = 1'b1;
        pick_oh[idx] = 1'b1;
        pick_idx     = PW'(idx);
      end
    end
  end

  always_comb begin
    grant_d = grant_q;
    dwell_d = dwell_q;
    ptr_d   = ptr_q;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_oh;
          dwell_d = '0;
          ptr_d   = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      default: begin
        if (dwell_q != DWELL_MAX) dwell_d = dwell_q + 1'b1;
        if (!(|(req & grant_q)) || (dwell_q == DWELL_MAX && others)) begin
          if (others) begin
            grant_d = pick_oh;
            dwell_d = '0;
            ptr_d   = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
          end else begin
            grant_d = '0;
            dwell_d = '0;
          end
        end
      end
    endcase
  end

  always_comb begin
    slice = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) slice = slice | req_num[40*i +: 40];
    end
  end

`ifdef DISPLAY_SHARE_BLINK_EN
  localparam int unsigned BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  logic [BW-1:0] bcnt_q;
  logic          phase_q;

  // Phase 0 shows the slice; restarts whenever the grant changes.
  always_ff @(posedge clk) begin
    if (rst || grant_d != grant_q) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else if (bcnt_q == BW'(BLINK_CYC - 1)) begin
      bcnt_q  <= '0;
      phase_q <= ~phase_q;
    end else begin
      bcnt_q  <= bcnt_q + 1'b1;
    end
  end

  assign blank_now = (|(blink & grant_q)) & phase_q;
`else
  assign blank_now = 1'b0;
`endif

  assign num_d = (state == ST_IDLE || blank_now) ? BLANK : slice;

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      dwell_q <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      num_q   <= BLANK;
    end else begin
      grant_q <= grant_d;
      dwell_q <= dwell_d;
      ptr_q   <= ptr_d;
      busy_q  <= |grant_d;
      num_q   <= num_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign num   = num_q;

endmodule

// File: tb/tb_display_share_arbiter.sv
// Directed bench for display_share_arbiter (NREQ=4, DWELL_CYC=4, BLINK_CYC=3).
module tb_display_share_arbiter;

  localparam logic [39:0] BLANK = 40'hFF_FFFF_FFFF;
  localparam logic [39:0] D0 = 40'hA0_A0A0_A0A0;
  localparam logic [39:0] D1 = 40'hB1_B1B1_B1B1;
  localparam logic [39:0] D2 = 40'hC2_C2C2_C2C2;
  localparam logic [39:0] D3 = 40'hD3_D3D3_D3D3;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [159:0] req_num;
  logic [3:0]   grant;
  logic         busy;
  logic [39:0]  num;
`ifdef DISPLAY_SHARE_BLINK_EN
  logic [3:0]   blink;
`endif

  int checks = 0;
  int errors = 0;

  display_share_arbiter #(
    .NREQ(4),
    .DWELL_CYC(4),
    .BLANK_CODE(5'h1F),
    .BLINK_CYC(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_num(req_num),
`ifdef DISPLAY_SHARE_BLINK_EN
    .blink(blink),
`endif
    .grant(grant),
    .busy(busy),
    .num(num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    cyc(2);
    rst = 1'b0;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want %b", grant, 4'b0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want %b", busy, 1'b0); end
    checks++; if (num !== BLANK) begin errors++; $display("FAIL reset_num got %h want %h", num, BLANK); end
    cyc(5);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL idle_grant got %b want %b", grant, 4'b0000); end
    checks++; if (num !== BLANK) begin errors++; $display("FAIL idle_num got %h want %h", num, BLANK); end
  endtask

  task automatic test_two_req_and_drop();
    req = 4'b0110;
    cyc(1);
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL first_grant got %b want %b", grant, 4'b0010); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_busy got %b want %b", busy, 1'b1); end
    checks++; if (num !== BLANK) begin errors++; $display("FAIL num_lag got %h want %h", num, BLANK); end
    cyc(1);
    checks++; if (num !== D1) begin errors++; $display("FAIL num_slice1 got %h want %h", num, D1); end
    cyc(2);
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL dwell_hold got %b want %b", grant, 4'b0010); end
    cyc(1);
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL dwell_switch got %b want %b", grant, 4'b0100); end
    cyc(1);
    checks++; if (num !== D2) begin errors++; $display("FAIL num_slice2 got %h want %h", num, D2); end
    // grant 0100 at dwell 1: dropping req[2] hands over immediately
    req = 4'b1010;
    cyc(1);
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL drop_switch got %b want %b", grant, 4'b1000); end
    req = 4'b0000;
    cyc(1);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL drop_idle got %b want %b", grant, 4'b0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %b want %b", busy, 1'b0); end
    checks++; if (num !== D3) begin errors++; $display("FAIL drop_num_lag got %h want %h", num, D3); end
    cyc(1);
    checks++; if (num !== BLANK) begin errors++; $display("FAIL drop_num_blank got %h want %h", num, BLANK); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    req = 4'b1111;
    for (int k = 0; k < 17; k++) begin
      cyc(1);
      exp = 4'b0001 << ((k / 4) % 4);
      checks++; if (grant !== exp) begin errors++; $display("FAIL rr_cycle%0d got %b want %b", k, grant, exp); end
    end
    req = 4'b0000;
    cyc(2);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rr_idle got %b want %b", grant, 4'b0000); end
  endtask

  task automatic test_single_saturate();
    req = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_cycle%0d got %b want %b", k, grant, 4'b0001); end
    end
    checks++; if (num !== D0) begin errors++; $display("FAIL single_num got %h want %h", num, D0); end
    req_num[39:0] = 40'h1;
    cyc(1);
    checks++; if (num !== 40'h1) begin errors++; $display("FAIL live_update got %h want %h", num, 40'h1); end
    req_num[39:0] = D0;
    // saturated dwell: a new request switches on the next edge
    req = 4'b0101;
    cyc(1);
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL sat_switch got %b want %b", grant, 4'b0100); end
    req = 4'b0000;
    cyc(2);
    checks++; if (num !== BLANK) begin errors++; $display("FAIL single_blank got %h want %h", num, BLANK); end
  endtask

  task automatic test_reset_mid_dwell();
    req = 4'b0100;
    cyc(1);
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL pre_rst_grant got %b want %b", grant, 4'b0100); end
    cyc(1);
    rst = 1'b1;
    req = 4'b1111;
    cyc(1);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL mid_rst_grant got %b want %b", grant, 4'b0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want %b", busy, 1'b0); end
    checks++; if (num !== BLANK) begin errors++; $display("FAIL mid_rst_num got %h want %h", num, BLANK); end
    rst = 1'b0;
    cyc(1);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL post_rst_grant got %b want %b", grant, 4'b0001); end
    cyc(1);
    checks++; if (num !== D0) begin errors++; $display("FAIL post_rst_num got %h want %h", num, D0); end
  endtask

`ifdef DISPLAY_SHARE_BLINK_EN
  task automatic test_blink();
    logic [39:0] exp;
    // continues from test_reset_mid_dwell: grant 0001 taken one edge ago
    req   = 4'b0001;
    blink = 4'b0001;
    for (int k = 2; k <= 13; k++) begin
      cyc(1);
      exp = (((k - 1) / 3) % 2 == 1) ? BLANK : D0;
      checks++; if (num !== exp) begin errors++; $display("FAIL blink_k%0d got %h want %h", k, num, exp); end
    end
    blink = 4'b0000;
    req   = 4'b0000;
    cyc(2);
  endtask
`endif

  initial begin
    rst     = 1'b1;
    req     = '0;
    req_num = {D3, D2, D1, D0};
`ifdef DISPLAY_SHARE_BLINK_EN
    blink   = '0;
`endif
    test_reset();
    test_two_req_and_drop();
    test_round_robin();
    test_single_saturate();
    test_reset_mid_dwell();
`ifdef DISPLAY_SHARE_BLINK_EN
    test_blink();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
